// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states, op classes and IR field positions shared by the control unit
package cpu_pkg;
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;
    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
    typedef enum logic [3:0] {
        CL_ALU_R, CL_ALU_I, CL_MULDIV, CL_UNARY, CL_LDI, CL_LD, CL_ST,
        CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } op_class_t;
endpackage

// File: rtl/op_class_decode.sv
// op_class_decode: maps a 5-bit opcode to its execute-sequence class
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [4:0] op,
    output op_class_t  cls
);
    // br/jr/jal/in/out and reserved codes share the nop sequence
    always_comb
        cls = (op == OP_LD)                      ? CL_LD     :
              (op == OP_LDI)                     ? CL_LDI    :
              (op == OP_ST)                      ? CL_ST     :
              (op >= OP_ADD  && op <= OP_ROL)    ? CL_ALU_R  :
              (op >= OP_ADDI && op <= OP_ORI)    ? CL_ALU_I  :
              (op == OP_MUL  || op == OP_DIV)    ? CL_MULDIV :
              (op == OP_NEG  || op == OP_NOT)    ? CL_UNARY  :
              (op == OP_MFHI)                    ? CL_MFHI   :
              (op == OP_MFLO)                    ? CL_MFLO   :
              (op == OP_HALT)                    ? CL_HALT   : CL_NOP;
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer driving the datapath strobes
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
    output logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    output logic        Gra, Grb, Grc,
    output logic        Rin, Rout, BAout, Cout,
    output logic        IncPC, Read, Write,
    output logic [4:0]  opcode,
    output logic        Run
);
    state_t    state, nxt;
    op_class_t cls;
    logic [4:0] op;
    logic unused_ir;

    assign op = IR[OP_HI:OP_LO];
    assign unused_ir = ^IR[RA_HI:0];

    op_class_decode u_dec (.op(op), .cls(cls));

    always_comb begin
        nxt = T0;
        case (state)
            T2:   nxt = (cls == CL_HALT) ? HALT : (cls == CL_NOP) ? T0 : T3;
            T3:   nxt = (cls == CL_MFHI || cls == CL_MFLO) ? T0 : T4;
            T4:   nxt = (cls == CL_UNARY) ? T0 : T5;
            T5:   nxt = (cls == CL_LD || cls == CL_ST || cls == CL_MULDIV) ? T6 : T0;
            T6:   nxt = (cls == CL_MULDIV) ? T0 : T7;
            T0:   nxt = T1;
            T1:   nxt = T2;
            HALT: nxt = HALT;
            default: nxt = T0;
        endcase
    end

    always_ff @(posedge Clock)
        state <= Clear ? RST : nxt;

    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout, IncPC, Read, Write} = '0;
        opcode = '0;
        Run = (state != RST) && (state != HALT);
        case (state)
            T0: {PCout, MARin, IncPC, Zin} = '1;
            T1: {Zlowout, PCin, Read, MDRin} = '1;
            T2: {MDRout, IRin} = '1;
            T3: case (cls)
                CL_ALU_R, CL_ALU_I:   {Grb, Rout, Yin} = '1;
                CL_MULDIV:            {Gra, Rout, Yin} = '1;
                CL_UNARY: begin {Grb, Rout, Zin} = '1; opcode = op; end
                CL_LDI, CL_LD, CL_ST: {Grb, BAout, Yin} = '1;
                CL_MFHI:              {HIout, Gra, Rin} = '1;
                CL_MFLO:              {LOout, Gra, Rin} = '1;
                default: ;
            endcase
            T4: case (cls)
                CL_ALU_R:  begin {Grc, Rout, Zin} = '1; opcode = op; end
                CL_ALU_I:  begin {Cout, Zin} = '1; opcode = op; end
                CL_MULDIV: begin {Grb, Rout, Zin} = '1; opcode = op; end
                CL_UNARY:  {Zlowout, Gra, Rin} = '1;
                CL_LDI, CL_LD, CL_ST: begin {Cout, Zin} = '1; opcode = OP_ADD; end
                default: ;
            endcase
            T5: case (cls)
                CL_ALU_R, CL_ALU_I, CL_LDI: {Zlowout, Gra, Rin} = '1;
                CL_MULDIV:                  {Zlowout, LOin} = '1;
                CL_LD, CL_ST:               {Zlowout, MARin} = '1;
                default: ;
            endcase
            T6: case (cls)
                CL_MULDIV: {Zhighout, HIin} = '1;
                CL_LD:     {Read, MDRin} = '1;
                CL_ST:     {Gra, Rout, MDRin} = '1;
                default: ;
            endcase
            T7: case (cls)
                CL_LD:   {MDRout, Gra, Rin} = '1;
                CL_ST:   Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed instruction sequences checked cycle by cycle against a queue of expected strobe vectors
module tb_control_unit;
    logic Clock = 1'b0, Clear = 1'b1;
    logic [31:0] IR = 32'h0;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, IncPC, Read, Write, Run;
    logic [4:0] opcode;
    logic [29:0] obs, exp_v;
    logic [29:0] sb[$];
    int checks = 0, failures = 0;

    localparam logic [29:0] PCO=30'd1<<0, ZHO=30'd1<<1, ZLO=30'd1<<2, MDO=30'd1<<3, HIO=30'd1<<4, LOO=30'd1<<5;
    localparam logic [29:0] PCI=30'd1<<6, IRI=30'd1<<7, MAI=30'd1<<8, MDI=30'd1<<9, YI=30'd1<<10, ZI=30'd1<<11;
    localparam logic [29:0] HII=30'd1<<12, LOI=30'd1<<13, GA=30'd1<<14, GB=30'd1<<15, GC=30'd1<<16, RI=30'd1<<17;
    localparam logic [29:0] RO=30'd1<<18, BA=30'd1<<19, CO=30'd1<<20, INC=30'd1<<21, RD=30'd1<<22, WR=30'd1<<23, RUN=30'd1<<24;
    localparam logic [29:0] F0 = PCO|MAI|INC|ZI|RUN, F1 = ZLO|PCI|RD|MDI|RUN, F2 = MDO|IRI|RUN;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .IncPC(IncPC), .Read(Read), .Write(Write), .opcode(opcode), .Run(Run)
    );

    always #5 Clock = ~Clock;

    assign obs = {opcode, Run, Write, Read, IncPC, Cout, BAout, Rout, Rin, Grc, Grb, Gra,
                  LOin, HIin, Zin, Yin, MDRin, MARin, IRin, PCin, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

    function automatic logic [29:0] opf(input logic [4:0] o);
        return {o, 25'd0};
    endfunction

    task automatic step(input string tag, input logic [29:0] e);
        sb.push_back(e);
        @(negedge Clock);
        exp_v = sb.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic instr(input string tag, input logic [31:0] ir, input int n,
                         input logic [29:0] e0, e1, e2, e3, e4);
        logic [29:0] ex[5];
        ex = '{e0, e1, e2, e3, e4};
        step({tag, "_T0"}, F0);
        IR = ir;
        step({tag, "_T1"}, F1);
        step({tag, "_T2"}, F2);
        for (int i = 0; i < n; i++) step($sformatf("%s_T%0d", tag, i + 3), ex[i]);
    endtask

    initial begin
        IR = 32'h28918000;
        step("rst0", 30'd0);
        step("rst1", 30'd0);
        Clear = 1'b0;
        instr("and", 32'h28918000, 3, GB|RO|YI|RUN, GC|RO|ZI|opf(5'b00101)|RUN, ZLO|GA|RI|RUN, 0, 0);
        instr("neg", 32'h88800000, 2, GB|RO|ZI|opf(5'b10001)|RUN, ZLO|GA|RI|RUN, 0, 0, 0);
        instr("ld", 32'h00800055, 5, GB|BA|YI|RUN, CO|ZI|opf(5'b00011)|RUN, ZLO|MAI|RUN, RD|MDI|RUN, MDO|GA|RI|RUN);
        instr("st", 32'h10800055, 5, GB|BA|YI|RUN, CO|ZI|opf(5'b00011)|RUN, ZLO|MAI|RUN, GA|RO|MDI|RUN, WR|RUN);
        instr("ldi", 32'h08800055, 3, GB|BA|YI|RUN, CO|ZI|opf(5'b00011)|RUN, ZLO|GA|RI|RUN, 0, 0);
        instr("addi", 32'h60880007, 3, GB|RO|YI|RUN, CO|ZI|opf(5'b01100)|RUN, ZLO|GA|RI|RUN, 0, 0);
        instr("div", 32'h80880000, 4, GA|RO|YI|RUN, GB|RO|ZI|opf(5'b10000)|RUN, ZLO|LOI|RUN, ZHO|HII|RUN, 0);
        instr("mfhi", 32'hC0800000, 1, HIO|GA|RI|RUN, 0, 0, 0, 0);
        instr("mflo", 32'hC8800000, 1, LOO|GA|RI|RUN, 0, 0, 0, 0);
        instr("nop", 32'hD0000000, 0, 0, 0, 0, 0, 0);
        instr("br", 32'h98000000, 0, 0, 0, 0, 0, 0);
        instr("mul", 32'h78880000, 2, GA|RO|YI|RUN, GB|RO|ZI|opf(5'b01111)|RUN, 0, 0, 0);
        Clear = 1'b1;
        step("mul_clr", 30'd0);
        Clear = 1'b0;
        instr("halt", 32'hD8000000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step($sformatf("halt_hold%0d", i), 30'd0);
        Clear = 1'b1;
        step("halt_clr", 30'd0);
        Clear = 1'b0;
        step("restart_T0", F0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
